// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-step logic/add/sub/slt ops plus iterative shift-add multiply
// and restoring unsigned divide/remainder, with valid/ready handshakes on both sides.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [2:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa, opb, acc;
  logic [CNT_W-1:0] cnt;
  logic             accept, iter_op;

  logic signed [WIDTH-1:0] src1_s, src2_s;
  logic [WIDTH-1:0]        sum, diff, ss_res;
  logic                    ss_ovf;

  logic [WIDTH-1:0] mul_acc_next, quo_next, rem_next, iter_res;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;

  function automatic logic signed_ovf(input logic is_sub, input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] r);
    logic same_sign;
    same_sign = (a[WIDTH-1] == b[WIDTH-1]);
    return (is_sub ? !same_sign : same_sign) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);
  assign accept    = in_valid && in_ready;
  assign iter_op   = (aluc == OP_MUL) || (aluc == OP_DIVU) || (aluc == OP_REMU);

  assign src1_s = src1;
  assign src2_s = src2;
  assign sum    = src1 + src2;
  assign diff   = src1 - src2;

  always_comb begin
    ss_res = '0;
    ss_ovf = 1'b0;
    case (aluc)
      OP_AND: ss_res = src1 & src2;
      OP_OR:  ss_res = src1 | src2;
      OP_ADD: begin
        ss_res = sum;
        ss_ovf = signed_ovf(1'b0, src1, src2, sum);
      end
      OP_SUB: begin
        ss_res = diff;
        ss_ovf = signed_ovf(1'b1, src1, src2, diff);
      end
      OP_SLT: ss_res = {{(WIDTH-1){1'b0}}, (src1_s < src2_s)};
      default: ss_res = '0;
    endcase
  end

  // One iteration step: opa/opb/acc are multiplicand/multiplier/product for MUL,
  // and dividend-turning-quotient/divisor/partial-remainder for DIVU and REMU.
  always_comb begin
    mul_acc_next = opb[0] ? (acc + opa) : acc;
    rem_sh       = {acc, opa[WIDTH-1]};
    div_ge       = (rem_sh >= {1'b0, opb});
    rem_next     = div_ge ? WIDTH'(rem_sh - {1'b0, opb}) : rem_sh[WIDTH-1:0];
    quo_next     = {opa[WIDTH-2:0], div_ge};
    case (op)
      OP_MUL:  iter_res = mul_acc_next;
      OP_DIVU: iter_res = quo_next;
      default: iter_res = rem_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = iter_op ? CALC : DONE;
      CALC: if (cnt == CNT_LAST) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand/iteration registers need no reset; result flags and counter do.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op  <= aluc;
          opa <= src1;
          opb <= src2;
          acc <= '0;
          if (iter_op) begin
            cnt <= CNT_LOAD;
          end else begin
            result   <= ss_res;
            zero     <= (ss_res == '0);
            overflow <= ss_ovf;
          end
        end
        CALC: begin
          cnt <= cnt - CNT_LAST;
          if (op == OP_MUL) begin
            acc <= mul_acc_next;
            opa <= opa << 1;
            opb <= opb >> 1;
          end else begin
            acc <= rem_next;
            opa <= quo_next;
          end
          if (cnt == CNT_LAST) begin
            result   <= iter_res;
            zero     <= (iter_res == '0);
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a 32-bit and an 8-bit instance driven with directed and
// random operations, checked by a plain-arithmetic reference model.
module tb_alu_mc;

  typedef struct {
    logic [31:0] res;
    bit          z;
    bit          ov;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_valid = 2'b00;
  logic [1:0]  out_ready = 2'b11;
  logic [31:0] a_src1 = '0, a_src2 = '0;
  logic [7:0]  b_src1 = '0, b_src2 = '0;
  logic [2:0]  a_aluc = '0, b_aluc = '0;
  wire  [1:0]  in_ready, out_valid, zero, ovf, busy;
  wire  [31:0] a_res;
  wire  [7:0]  b_res;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .src1(a_src1), .src2(a_src2), .aluc(a_aluc), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .result(a_res), .zero(zero[0]), .overflow(ovf[0]),
    .busy(busy[0])
  );

  alu_mc #(.WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .src1(b_src1), .src2(b_src2), .aluc(b_aluc), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .result(b_res), .zero(zero[1]), .overflow(ovf[1]),
    .busy(busy[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model straight from the operation definitions, using wide integers.
  function automatic void model(input int w, input logic [2:0] op,
                                input longint unsigned x, input longint unsigned y,
                                output longint unsigned r, output bit ov);
    longint unsigned m;
    longint sx, sy, s, mx, mn;
    m  = (64'd1 << w) - 64'd1;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    sx = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
    sy = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
    ov = 1'b0;
    r  = 0;
    case (op)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: begin r = (x + y) & m; s = sx + sy; ov = (s > mx) || (s < mn); end
      3'd6: begin r = (x - y) & m; s = sx - sy; ov = (s > mx) || (s < mn); end
      3'd7: r = (sx < sy) ? 1 : 0;
      3'd3: r = (x * y) & m;
      3'd4: r = (y == 0) ? m : x / y;
      default: r = (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic logic [31:0] cur_res(input int which);
    return (which == 0) ? a_res : {24'b0, b_res};
  endfunction

  task automatic issue(input int which, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y, input int hold, input string tag);
    int w, lat, guard;
    bit iter, bad;
    longint unsigned r;
    bit ov;
    exp_t e;
    logic [31:0] held;
    w = (which == 0) ? 32 : 8;
    iter = (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    guard = 0;
    while (!in_ready[which] && guard < 100) begin @(posedge clk); #1; guard++; end
    if (!in_ready[which]) chk({tag, "_ready_timeout"}, 0, 1);
    if (which == 0) begin
      model(w, op, longint'(x), longint'(y), r, ov);
      a_src1 = x; a_src2 = y; a_aluc = op;
    end else begin
      model(w, op, longint'(x[7:0]), longint'(y[7:0]), r, ov);
      b_src1 = x[7:0]; b_src2 = y[7:0]; b_aluc = op;
    end
    e.res = r[31:0]; e.z = (r == 0); e.ov = ov; e.tag = tag;
    if (which == 0) qa.push_back(e); else qb.push_back(e);
    out_ready[which] = (hold == 0);
    in_valid[which] = 1'b1;
    @(posedge clk); #1;
    in_valid[which] = 1'b0;
    // Operands wander after acceptance; the result must not follow them.
    if (which == 0) a_src1 = $urandom; else b_src1 = 8'($urandom);
    lat = 1;
    bad = 1'b0;
    while (!out_valid[which] && lat < 200) begin
      if (in_ready[which] || !busy[which]) bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, iter ? w + 1 : 1);
    if (iter) chk({tag, "_calc_flags"}, bad, 0);
    if (hold > 0) begin
      held = cur_res(which);
      bad = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (cur_res(which) !== held || in_ready[which] || !out_valid[which]) bad = 1'b1;
      end
      chk({tag, "_hold_stable"}, bad, 0);
      out_ready[which] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid[0] && out_ready[0]) begin
      if (qa.size() == 0) chk("a_unexpected_output", 1, 0);
      else begin
        ea = qa.pop_front();
        chk({ea.tag, "_result"}, a_res, ea.res);
        chk({ea.tag, "_zero"}, zero[0], ea.z);
        chk({ea.tag, "_overflow"}, ovf[0], ea.ov);
      end
    end
    if (rst_n && out_valid[1] && out_ready[1]) begin
      if (qb.size() == 0) chk("b_unexpected_output", 1, 0);
      else begin
        eb = qb.pop_front();
        chk({eb.tag, "_result"}, {24'b0, b_res}, eb.res);
        chk({eb.tag, "_zero"}, zero[1], eb.z);
        chk({eb.tag, "_overflow"}, ovf[1], eb.ov);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 2'b00);
    chk("rst_in_ready", in_ready, 2'b00);
    chk("rst_busy", busy, 2'b00);
    chk("rst_result_a", a_res, 0);
    chk("rst_result_b", b_res, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(0, 3'd0, 32'hF0F0_00FF, 32'h0FF0_FF0F, 0, "and");
    issue(0, 3'd1, 32'h0, 32'h0, 0, "or_zero");
    issue(0, 3'd2, 32'h7FFF_FFFF, 32'h1, 0, "add_ovf");
    issue(0, 3'd6, 32'h8000_0000, 32'h1, 0, "sub_ovf");
    issue(0, 3'd6, 32'd5, 32'd5, 0, "sub_zero");
    issue(0, 3'd7, 32'hFFFF_FFFF, 32'd1, 0, "slt_true");
    issue(0, 3'd7, 32'd1, 32'hFFFF_FFFF, 0, "slt_false");
    issue(0, 3'd3, 32'd1234, 32'd5678, 0, "mul");
    issue(0, 3'd4, 32'd100, 32'd7, 0, "divu");
    issue(0, 3'd5, 32'd100, 32'd7, 0, "remu");
    issue(0, 3'd4, 32'd37, 32'd0, 0, "divu_by0");
    issue(0, 3'd5, 32'd37, 32'd0, 0, "remu_by0");
    issue(0, 3'd2, 32'd3, 32'd4, 10, "add_backpressure");
    issue(0, 3'd4, 32'hDEAD_BEEF, 32'd13, 10, "divu_backpressure");

    // Reset in the middle of an iterative operation.
    a_src1 = 32'd9; a_src2 = 32'd9; a_aluc = 3'd3;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midreset_busy_before", busy[0], 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_out_valid", out_valid[0], 0);
    chk("midreset_busy", busy[0], 0);
    rst_n = 1'b1;
    #1;
    chk("midreset_idle_ready", in_ready[0], 1);
    repeat (40) @(posedge clk);
    #1;
    chk("midreset_no_output", out_valid[0], 0);

    issue(1, 3'd3, 32'h10, 32'h10, 0, "b_mul_wrap");
    issue(1, 3'd4, 32'd200, 32'd3, 0, "b_divu");
    for (int i = 0; i < 255; i++)
      issue(1, 3'($urandom_range(0, 7)), $urandom_range(0, 99), $urandom_range(0, 99),
            (i % 50 == 7) ? 3 : 0, "b_rand");

    repeat (3) @(posedge clk);
    #1;
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
